// File: rtl/counter.sv
// counter: wrapping up-counter with synchronous init and count enable.
// Define COUNTER_TC_EN to add the registered terminal-count flag tc_o.
module counter #(
    parameter int              NB_BITS    = 4,
    parameter longint unsigned INIT_VALUE = 64'd0,
    parameter longint unsigned MAX_VALUE  = (64'd1 << NB_BITS) - 64'd1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               init_i,
`ifdef COUNTER_TC_EN
    output logic               tc_o,
`endif
    output logic [NB_BITS-1:0] count_o
);
    localparam longint unsigned FULL_SCALE = (64'd1 << NB_BITS) - 64'd1;
    generate
        if (NB_BITS < 1 || NB_BITS > 32 || MAX_VALUE > FULL_SCALE || INIT_VALUE > MAX_VALUE) begin : g_bad_params
            $error("counter: illegal NB_BITS/INIT_VALUE/MAX_VALUE combination");
        end
    endgenerate
    localparam logic [NB_BITS-1:0] MAX_C  = MAX_VALUE[NB_BITS-1:0];
    localparam logic [NB_BITS-1:0] INIT_C = INIT_VALUE[NB_BITS-1:0];
    logic [NB_BITS-1:0] count_q, count_d;
    // wrap goes to zero, not INIT_VALUE, so a non-power-of-two MAX_VALUE still counts modulo MAX_VALUE+1
    always_comb begin
        count_d = init_i   ? INIT_C :
                  enable_i ? ((count_q == MAX_C) ? '0 : count_q + 1'b1) :
                             count_q;
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end
    assign count_o = count_q;
`ifdef COUNTER_TC_EN
    logic tc_q, tc_d;
    always_comb begin
        tc_d = enable_i && (count_d == MAX_C);
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) tc_q <= 1'b0;
        else         tc_q <= tc_d;
    end
    assign tc_o = tc_q;
`endif
endmodule

// File: tb/tb_counter.sv
// tb_counter: scoreboard bench for counter; a reference model queues expected values
// on every clock/reset event and an independent monitor pops and compares them.
module tb_counter;
    localparam int NB   = 4;
    localparam int INIT = 0;
    localparam int MAX  = 15;

    typedef struct { int cnt; int tc; } exp_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          enable_i = 1'b0;
    logic          init_i = 1'b0;
    logic [NB-1:0] count_o;
    logic          tc_o;
    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            m_cnt = 0;

    counter dut (
        .clock_i (clk),
        .reset_i (reset_i),
        .enable_i(enable_i),
        .init_i  (init_i),
`ifdef COUNTER_TC_EN
        .tc_o    (tc_o),
`endif
        .count_o (count_o)
    );
`ifndef COUNTER_TC_EN
    assign tc_o = 1'b0;
`endif

    always #5 clk = ~clk;

    // reference model: plain modular arithmetic on the rules, one entry per event
    always @(posedge clk or posedge reset_i) begin
        exp_t e;
        if (reset_i) m_cnt = 0;
        else if (init_i) m_cnt = INIT;
        else if (enable_i) m_cnt = (m_cnt + 1) % (MAX + 1);
        e.cnt = m_cnt;
        e.tc  = (!reset_i && enable_i && m_cnt == MAX) ? 1 : 0;
        sb.push_back(e);
    end

    // monitor: samples 1 ns after each event, away from the edge
    always @(posedge clk or posedge reset_i) begin
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_empty: no expected entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            checks++;
            if (count_o !== NB'(e.cnt)) begin
                errors++;
                $display("FAIL count at %0t: got %0d expected %0d", $time, count_o, e.cnt);
            end
`ifdef COUNTER_TC_EN
            checks++;
            if (tc_o !== 1'(e.tc)) begin
                errors++;
                $display("FAIL tc at %0t: got %0b expected %0d (count %0d)", $time, tc_o, e.tc, e.cnt);
            end
`endif
        end
    end

    task automatic drive(input logic en, input logic ini, input int n);
        repeat (n) begin
            enable_i = en;
            init_i   = ini;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset(input int hold_ns);
        #2 reset_i = 1'b1;
        #(hold_ns);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: time limit reached, checks=%0d", checks);
                $fatal(1, "watchdog");
            end
        join_none
        enable_i = 1'b0;
        init_i   = 1'b1;
        #1 reset_i = 1'b1;
        #12;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 3);
        pulse_reset(10);
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 2);
        drive(1'b1, 1'b0, 14);
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 20));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 1);
        end
        @(negedge clk);
        checks++;
        if (checks < 300) begin
            errors++;
            $display("FAIL check_count: got %0d expected at least 300", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
